// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared constants for the instruction-fetch SRAM-to-AXI read bridge.
package inst_sram_axi_rd_bridge_pkg;

    localparam int PcWidth      = 32;
    localparam int FETCH_ADDR_W = PcWidth;
    localparam int FETCH_DATA_W = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_1      = 8'd0;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [3:0] FETCH_ARID = 4'd0;

    // SLVERR (2'b10) and DECERR (2'b11) both have the upper bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/inst_bridge_cnt.sv
// Up/down counter with load, saturating at 0 and at MAX.
module inst_bridge_cnt
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         dec_eff;

    assign dec_eff = dec_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !dec_eff && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_eff && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_sram_axi_rd_bridge.sv
// SRAM-like fetch port to single-beat AXI4 read bridge with flush cancellation.
// Optional rresp error reporting is enabled with the IBRIDGE_RRESP_CHK_EN macro.
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID_VAL        = FETCH_ARID,
    parameter int         ADDR_W          = FETCH_ADDR_W,
    parameter int         DATA_W          = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_sram_req_i,
    input  logic [ADDR_W-1:0] inst_sram_raddr_i,
    output logic              inst_sram_addr_ok_o,
    output logic              inst_sram_data_ok_o,
    output logic [DATA_W-1:0] inst_sram_rdata_o,
    output logic              inst_bus_err_o,
    input  logic              excep_flush_i,
    output logic [3:0]        arid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [3:0]        rid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    localparam int            CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              rready_q;

    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  cancel_cnt;
    logic              accept;
    logic              rbeat;
    logic              drop;
    logic              unused_inputs;

    // Valid/ready: a transfer happens on a clock edge where valid and ready are both high;
    // once arvalid_o is raised, it and araddr_o stay fixed until arready_i is seen.
    assign inst_sram_addr_ok_o = inst_sram_req_i && !excep_flush_i
                               && (!arvalid_q || arready_i) && (out_cnt < MAX_CNT);
    assign accept = inst_sram_req_i && inst_sram_addr_ok_o;
    // A beat with nothing outstanding is a protocol violation and is ignored entirely.
    assign rbeat  = rvalid_i && rready_q && (out_cnt != '0);
    assign drop   = (cancel_cnt != '0);

    inst_bridge_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_out_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (accept),
        .dec_i      (rbeat),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (out_cnt)
    );

    // On flush every fetch still owed a beat becomes stale; in-order return lets a count suffice.
    inst_bridge_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_cancel_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (1'b0),
        .dec_i      (rbeat && drop),
        .load_i     (excep_flush_i),
        .load_val_i (out_cnt - CNT_W'(rbeat)),
        .cnt_o      (cancel_cnt)
    );

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_sram_raddr_i;
        end else if (arready_i) begin
            arvalid_d = 1'b0;
        end
        data_ok_d = rbeat && !drop && !excep_flush_i;
        rdata_d   = rbeat ? rdata_i : rdata_q;
`ifdef IBRIDGE_RRESP_CHK_EN
        bus_err_d = rbeat && !drop && !excep_flush_i && resp_is_err(rresp_i);
`else
        bus_err_d = 1'b0;
`endif
    end

`ifdef IBRIDGE_RRESP_CHK_EN
    assign unused_inputs = ^{rid_i, rlast_i};
`else
    assign unused_inputs = ^{rid_i, rlast_i, rresp_i};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            rready_q  <= 1'b1;
        end
    end

    assign arvalid_o           = arvalid_q;
    assign araddr_o            = araddr_q;
    assign arid_o              = ARID_VAL;
    assign arlen_o             = AXI_LEN_1;
    assign arsize_o            = AXI_SIZE_4B;
    assign arburst_o           = AXI_BURST_INCR;
    assign rready_o            = rready_q;
    assign inst_sram_data_ok_o = data_ok_q;
    assign inst_sram_rdata_o   = rdata_q;
    assign inst_bus_err_o      = bus_err_q;

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
- Responder for the pre-IF instruction-fetch request port (req / raddr / addr_ok).
- Accepts SRAM-like read requests and issues single-beat AXI4 AR transactions.
- Returns each word on a data_ok pulse to the IF stage, strictly in order.
- Sits between the fetch front end and the AXI crossbar; discards responses belonging to requests cancelled by an exception flush.

Parameters:
- MAX_OUTSTANDING, 2, max accepted requests without a returned R beat (1..4).
- ARID_VAL, 4'd0, constant ARID for all fetches.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_sram_req_i  in  1  fetch request.
- inst_sram_raddr_i  in  ADDR_W  fetch address.
- inst_sram_addr_ok_o  out  1  request accepted this cycle.
- inst_sram_data_ok_o  out  1  rdata valid, one pulse per accepted, non-cancelled request.
- inst_sram_rdata_o  out  DATA_W  fetched word.
- inst_bus_err_o  out  1  response error flag, qualified by data_ok.
- excep_flush_i  in  1  cancel all outstanding fetches.
- arid_o  out  4  ARID_VAL.
- araddr_o  out  ADDR_W.
- arlen_o  out  8  fixed 0.
- arsize_o  out  3  fixed 3'b010.
- arburst_o  out  2  fixed INCR.
- arvalid_o  out  1.
- arready_i  in  1.
- rid_i  in  4.
- rdata_i  in  DATA_W.
- rresp_i  in  2.
- rlast_i  in  1.
- rvalid_i  in  1.
- rready_o  out  1  constant 1 out of reset.

Behaviour:
- Reset (async, rst_n=0): arvalid_o=0, araddr_o=0, data_ok_o=0, rdata_o=0, bus_err_o=0, out_cnt=0, cancel_cnt=0, rready_o=0. rready_o is 1 from the first clk after release.
- accept = req_i && addr_ok_o.
- addr_ok_o is combinational and equals req_i && !excep_flush_i && (!arvalid_o || arready_i) && (out_cnt < MAX_OUTSTANDING).
- AR register:
  - On accept: arvalid_o<=1, araddr_o<=raddr_i.
  - Else if arready_i: arvalid_o<=0.
  - While arvalid_o && !arready_i, araddr_o/arvalid_o are held (AXI rule), including across a flush.
- Latency: accept at cycle T gives arvalid_o at T+1. A back-to-back accept at T+1 is allowed when arready_i=1 at T+1.
- rbeat = rvalid_i && rready_o. rlast_i is ignored (single beat). rid_i is not checked.
- out_cnt counts accepted requests with no R beat yet:
  - +1 on accept, −1 on rbeat, both in the same cycle gives no change.
  - Width $clog2(MAX_OUTSTANDING+1).
- drop = (cancel_cnt != 0).
- Response registers, updated each cycle:
  - data_ok_o <= rbeat && !drop && !excep_flush_i.
  - rdata_o <= rdata_i when rbeat, else hold.
  - bus_err_o per the optional feature.
- Responses are in order (single ID), so the cancel count alone identifies stale beats.
- Cancel handling:
  - On excep_flush_i: cancel_cnt <= out_cnt − rbeat. The beat in the flush cycle is itself suppressed through data_ok.
  - Otherwise on rbeat && drop: cancel_cnt−1.
  - New requests may be accepted while cancel_cnt≠0. Their beats arrive after all cancelled beats.
- Flush while the AR is still pending: that AR still completes and is counted in cancel_cnt.
- Flush with out_cnt=0: no effect beyond blocking addr_ok that cycle.
- Full: out_cnt==MAX_OUTSTANDING forces addr_ok_o=0; a simultaneous rbeat does not unblock it in the same cycle.
- A beat arriving with out_cnt==0 is a protocol violation. It is ignored, and out_cnt does not underflow (saturates at 0).
- Reset mid-operation clears all state; pending AXI transactions are abandoned.

Optional Feature:
- Macro IBRIDGE_RRESP_CHK_EN.
- Defined: bus_err_o <= rbeat && !drop && !excep_flush_i && rresp_i[1] (SLVERR/DECERR). rdata is still returned with data_ok.
- Undefined: bus_err_o is constant 0 and rresp_i is unused.

Decomposition:
- Shared package/header: AXI constants (AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_LEN_1=8'd0, AXI_RESP_OKAY=2'b00), fetch ID value, width macros alongside the existing PcWidth.
- One sub-module is natural: inst_bridge_cnt, an up/down saturating counter with load, instantiated twice (out_cnt and cancel_cnt).

Test Plan:
- Single fetch: req, raddr=0x1C000000, arready=1, rvalid 3 cycles later with rdata=0x02800C0C → addr_ok at T, arvalid T+1, one data_ok with rdata 0x02800C0C, out_cnt back to 0.
- Back-pressure: arready=0 for 4 cycles with a second req pending → addr_ok=0 throughout, araddr held, second accept on the first arready cycle.
- Full: MAX_OUTSTANDING=2, three consecutive reqs, no R → third addr_ok=0 until the first rbeat's next cycle.
- Flush: 2 outstanding (0x100, 0x104), flush, then new req 0x200; R beats A, B, C → only C's data produces data_ok, cancel_cnt 2→0.
- Flush coincident with rbeat and out_cnt=2 → that beat suppressed, cancel_cnt=1, the next beat dropped.
- With IBRIDGE_RRESP_CHK_EN, rresp=2'b10 → data_ok=1 and bus_err=1 in the same cycle; without the macro, bus_err stays 0.
